window_apply_sequencer: RTL and testbench

Frame-level sequencer that applies the analysis window to one audio frame before the FFT. For each index it reads a sample and the matching window coefficient from two synchronous-read memories. It then drives the shared 16-bit fixed-point multiplier through its enable/done handshake and writes the windowed product into the FFT input buffer. It sits between the sample frame buffer / window ROM and the FFT input RAM, directly upstream of the fixed-point multiplier.

---
 rtl/window_apply_sequencer.sv | 135 +++++++++++++
 tb/tb_window_apply_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_apply_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : window_apply_sequencer
//  Brief    : Applies the analysis window to one frame ahead of the FFT.
//             Each index is read, multiplied, then written to the FFT input RAM.
//  Revision : 1.0  initial release
// ============================================================================
module window_apply_sequencer #(
  parameter int N_POINTS   = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  smp_rd_en,
  output logic [ADDR_WIDTH-1:0] smp_addr,
  input  logic [15:0]           smp_data,
  output logic                  win_rd_en,
  output logic [ADDR_WIDTH-1:0] win_addr,
  input  logic [15:0]           win_data,
  output logic                  mul_enable,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [15:0]           mul_product,
  input  logic                  mul_done,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [15:0]           out_data
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(N_POINTS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_MUL   = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_next;
  logic                  w_busy_next;
  logic                  w_rd_en_next;
  logic                  w_mul_enable_next;
  logic                  w_out_we_next;
  logic                  w_frame_done_next;
  logic                  w_load_operands;
  logic                  w_capture_product;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_idx_next   = '0;
        end
      end
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_MUL;
      S_MUL:   w_state_next = S_WAIT;
      S_WAIT: begin
        if (mul_done) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_FETCH;
          w_idx_next   = r_idx + 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Strobes are derived from the next state so they register in step with it.
    w_busy_next       = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
    w_rd_en_next      = (w_state_next == S_FETCH);
    w_mul_enable_next = (w_state_next == S_MUL);
    w_out_we_next     = (w_state_next == S_WRITE);
    w_frame_done_next = (w_state_next == S_DONE);
    w_load_operands   = (r_state == S_LOAD);
    w_capture_product = (r_state == S_WAIT) && mul_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      smp_rd_en  <= 1'b0;
      win_rd_en  <= 1'b0;
      smp_addr   <= '0;
      win_addr   <= '0;
      mul_enable <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      busy       <= w_busy_next;
      frame_done <= w_frame_done_next;
      smp_rd_en  <= w_rd_en_next;
      win_rd_en  <= w_rd_en_next;
      mul_enable <= w_mul_enable_next;
      out_we     <= w_out_we_next;
      if (w_rd_en_next) begin
        smp_addr <= w_idx_next;
        win_addr <= w_idx_next;
      end
      // Operands stay put until the next LOAD; the multiplier re-reads them.
      if (w_load_operands) begin
        mul_a <= smp_data;
        mul_b <= win_data;
      end
      if (w_capture_product) out_data <= mul_product;
      if (w_out_we_next)     out_addr <= w_idx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_apply_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_apply_sequencer
//  Brief    : Scoreboard bench with memory and multiplier models for a 4-point frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_window_apply_sequencer;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk, reset, start;
  logic          busy, frame_done;
  logic          smp_rd_en, win_rd_en;
  logic [AW-1:0] smp_addr, win_addr, out_addr;
  logic [15:0]   smp_data, win_data;
  logic          mul_enable, mul_done, out_we;
  logic [15:0]   mul_a, mul_b, mul_product, out_data;

  window_apply_sequencer #(.N_POINTS(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .smp_rd_en(smp_rd_en), .smp_addr(smp_addr), .smp_data(smp_data),
    .win_rd_en(win_rd_en), .win_addr(win_addr), .win_data(win_data),
    .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] smp_mem[N];
  logic [15:0] win_mem[N];
  logic [15:0] basic_exp[N] = '{16'h0080, 16'hFF80, 16'h7FFE, 16'h0000};
  logic [AW-1:0] last_addr = '0;
  int cyc = 0, n_pass = 0, n_total = 0;
  int mul_k = 2, epoch = 0;
  bit spur_arm = 0;
  int we_count = 0, done_count = 0, en_count = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Fixed-point multiply: (A*B) >> 15, saturated to 16 bits.
  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    p = p >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  // Synchronous-read sample memory and window ROM; noise when not read.
  initial begin : mem_model
    bit en, wen;
    logic [AW-1:0] a, wa;
    forever begin
      @(negedge clk);
      en = smp_rd_en; a = smp_addr; wen = win_rd_en; wa = win_addr;
      if (en) last_addr = a;
      @(posedge clk);
      #1;
      smp_data = en  ? smp_mem[a]  : 16'($urandom);
      win_data = wen ? win_mem[wa] : 16'($urandom);
    end
  end

  // Multiplier: done k cycles after enable, product formed from live operands.
  initial begin : mul_model
    logic [15:0] a, b;
    int ep;
    mul_done = 0;
    mul_product = 0;
    forever begin
      @(negedge clk);
      if (spur_arm && out_we && out_addr != AW'(N - 1)) begin
        spur_arm = 0;
        @(posedge clk); #1 mul_done = 1;
        @(posedge clk); #1 mul_done = 0;
      end else if (mul_enable) begin
        ep = epoch; a = mul_a; b = mul_b;
        chk(mul_a == smp_mem[last_addr], "operand_a", int'(mul_a), int'(smp_mem[last_addr]));
        chk(mul_b == win_mem[last_addr], "operand_b", int'(mul_b), int'(win_mem[last_addr]));
        for (int i = 1; i < mul_k; i++) begin
          @(negedge clk);
          if (ep == epoch) begin
            chk(mul_a == a && mul_b == b, "operand_hold", int'({mul_a, mul_b}), int'({a, b}));
            chk(!mul_enable, "extra_mul_enable", int'(mul_enable), 0);
          end
        end
        @(posedge clk);
        #1;
        if (ep == epoch) begin
          mul_product = qmul(mul_a, mul_b);
          mul_done = 1;
        end
        @(negedge clk);
        if (ep == epoch)
          chk(mul_a == a && mul_b == b, "operand_hold_done", int'({mul_a, mul_b}), int'({a, b}));
        @(posedge clk);
        #1 mul_done = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every write, checking address, data and cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mul_enable) en_count++;
      if (frame_done) done_count++;
      if (out_we) begin
        we_count++;
        chk(q.size() > 0, "write_expected", int'(out_addr), -1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk(out_addr == e.addr, "wr_addr", int'(out_addr), int'(e.addr));
          chk(out_data == e.data, "wr_data", int'(out_data), int'(e.data));
          chk(cyc == e.cyc, "wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk(busy == 0,       {tag, "_busy"},       int'(busy), 0);
    chk(frame_done == 0, {tag, "_frame_done"}, int'(frame_done), 0);
    chk(smp_rd_en == 0,  {tag, "_smp_rd_en"},  int'(smp_rd_en), 0);
    chk(win_rd_en == 0,  {tag, "_win_rd_en"},  int'(win_rd_en), 0);
    chk(mul_enable == 0, {tag, "_mul_enable"}, int'(mul_enable), 0);
    chk(out_we == 0,     {tag, "_out_we"},     int'(out_we), 0);
    chk(smp_addr == 0,   {tag, "_smp_addr"},   int'(smp_addr), 0);
    chk(win_addr == 0,   {tag, "_win_addr"},   int'(win_addr), 0);
    chk(out_addr == 0,   {tag, "_out_addr"},   int'(out_addr), 0);
    chk(mul_a == 0,      {tag, "_mul_a"},      int'(mul_a), 0);
    chk(mul_b == 0,      {tag, "_mul_b"},      int'(mul_b), 0);
    chk(out_data == 0,   {tag, "_out_data"},   int'(out_data), 0);
  endtask

  task automatic randomize_mems();
    for (int i = 0; i < N; i++) begin
      smp_mem[i] = 16'($urandom);
      win_mem[i] = 16'($urandom);
    end
  endtask

  // Issues start at the current negedge and queues the writes the frame must produce.
  task automatic start_frame(input bit use_basic, output int t);
    exp_t e;
    t = cyc;
    start = 1;
    for (int i = 0; i < N; i++) begin
      e.addr = AW'(i);
      e.data = use_basic ? basic_exp[i] : qmul(smp_mem[i], win_mem[i]);
      e.cyc  = t + (4 + mul_k) * (i + 1);
      q.push_back(e);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int exp_cyc, input string tag);
    for (int i = 0; i < 2000 && !frame_done; i++) @(negedge clk);
    chk(frame_done == 1, {tag, "_done_seen"}, int'(frame_done), 1);
    chk(cyc == exp_cyc, {tag, "_done_cycle"}, cyc, exp_cyc);
    chk(busy == 0, {tag, "_busy_in_done"}, int'(busy), 0);
  endtask

  initial begin : stim
    int t, we0, done0, en0;
    reset = 1; start = 0;
    smp_data = 0; win_data = 0;
    for (int i = 0; i < N; i++) begin
      smp_mem[i] = 0;
      win_mem[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 0;
    repeat (2) @(negedge clk);

    // Basic frame with the reference vectors.
    smp_mem = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h0000};
    win_mem = '{16'h4000, 16'h4000, 16'h7FFF, 16'h7FFF};
    mul_k = 2;
    start_frame(1'b1, t);
    chk(busy == 1, "busy_t1", int'(busy), 1);
    chk(smp_rd_en && win_rd_en, "rd_en_t1", int'({smp_rd_en, win_rd_en}), 3);
    chk(smp_addr == 0 && win_addr == 0, "rd_addr_t1", int'({smp_addr, win_addr}), 0);
    repeat (2) @(negedge clk);
    chk(mul_enable == 1, "mul_enable_t3", int'(mul_enable), 1);
    wait_done(t + 25, "basic");
    repeat (3) @(negedge clk);

    // Zero coefficient plus a saturating corner, slightly slower multiplier.
    randomize_mems();
    smp_mem[1] = 16'h1234; win_mem[1] = 16'h0000;
    smp_mem[2] = 16'h8000; win_mem[2] = 16'h8000;
    mul_k = 3;
    start_frame(1'b0, t);
    wait_done(t + 7 * N + 1, "zero_coef");
    repeat (3) @(negedge clk);

    // Start pulsed mid-frame must be ignored.
    randomize_mems();
    mul_k = int'($urandom_range(1, 3));
    done0 = done_count; we0 = we_count;
    start_frame(1'b0, t);
    for (int i = 0; i < 200 && !(smp_rd_en && smp_addr == 2); i++) @(negedge clk);
    chk(smp_rd_en && smp_addr == 2, "reach_idx2", int'(smp_addr), 2);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(t + (4 + mul_k) * N + 1, "ignore_start");
    repeat (8) @(negedge clk);
    chk(done_count - done0 == 1, "ignore_start_done_cnt", done_count - done0, 1);
    chk(we_count - we0 == N, "ignore_start_we_cnt", we_count - we0, N);

    // Reset during WAIT of idx 1, then a clean frame.
    randomize_mems();
    mul_k = 2;
    start_frame(1'b0, t);
    for (int i = 0; i < 200 && !(mul_enable && last_addr == 1); i++) @(negedge clk);
    chk(mul_enable && last_addr == 1, "reach_mul_idx1", int'(last_addr), 1);
    @(negedge clk);
    reset = 1;
    epoch++;
    @(negedge clk);
    check_idle_outputs("midreset");
    q.delete();
    reset = 0;
    repeat (3) @(negedge clk);
    randomize_mems();
    start_frame(1'b0, t);
    wait_done(t + 25, "after_reset");
    repeat (3) @(negedge clk);

    // Stalled multiplier with a spurious done during FETCH.
    randomize_mems();
    mul_k = 5;
    spur_arm = 1;
    en0 = en_count;
    start_frame(1'b0, t);
    wait_done(t + 9 * N + 1, "stalled");
    repeat (3) @(negedge clk);
    chk(en_count - en0 == N, "stalled_enable_cnt", en_count - en0, N);

    // Back-to-back frames.
    randomize_mems();
    mul_k = 2;
    done0 = done_count; we0 = we_count;
    start_frame(1'b0, t);
    wait_done(t + 25, "b2b_first");
    @(negedge clk);
    start_frame(1'b0, t);
    wait_done(t + 25, "b2b_second");
    repeat (4) @(negedge clk);
    chk(we_count - we0 == 2 * N, "b2b_we_cnt", we_count - we0, 2 * N);
    chk(done_count - done0 == 2, "b2b_done_cnt", done_count - done0, 2);

    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
